// File: rtl/ex_div_if.sv
// rtl/ex_div_if.sv - EX-stage divider operand/result bundle
interface ex_div_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  exception_i;
    logic                  start_i;
    logic                  signed_i;
    logic [DATA_WIDTH-1:0] dividend_i;
    logic [DATA_WIDTH-1:0] divisor_i;
    logic                  accept_i;
    logic                  stall_o;
    logic                  busy_o;
    logic                  done_o;
    logic [DATA_WIDTH-1:0] quotient_o;
    logic [DATA_WIDTH-1:0] remainder_o;

    modport slave (
        input  exception_i, start_i, signed_i, dividend_i, divisor_i, accept_i,
        output stall_o, busy_o, done_o, quotient_o, remainder_o
    );

    modport master (
        output exception_i, start_i, signed_i, dividend_i, divisor_i, accept_i,
        input  stall_o, busy_o, done_o, quotient_o, remainder_o
    );
endinterface

// File: rtl/ex_div.sv
// rtl/ex_div.sv - iterative restoring DIV/DIVU unit for the EX stage
module ex_div #(
    parameter int DATA_WIDTH = 32
) (
    input  logic   clock_i,
    input  logic   reset_i,
    ex_div_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] quo;
    logic [DATA_WIDTH-1:0] dsr;
    logic                  q_neg;
    logic                  r_neg;
    logic [DATA_WIDTH-1:0] quotient_r;
    logic [DATA_WIDTH-1:0] remainder_r;
    logic                  done_r;
    logic                  busy_r;

    logic [DATA_WIDTH:0]   trial;
    logic [DATA_WIDTH-1:0] rem_next;
    logic [DATA_WIDTH-1:0] quo_next;
    logic [DATA_WIDTH-1:0] dvd_abs;
    logic [DATA_WIDTH-1:0] dsr_abs;
    logic [DATA_WIDTH-1:0] quo_fin;
    logic [DATA_WIDTH-1:0] rem_fin;

    // quo doubles as the dividend shift register: its MSB feeds the partial remainder
    always_comb begin
        trial    = {rem, quo[DATA_WIDTH-1]} - {1'b0, dsr};
        quo_next = {quo[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
        rem_next = trial[DATA_WIDTH] ? {rem[DATA_WIDTH-2:0], quo[DATA_WIDTH-1]}
                                     : trial[DATA_WIDTH-1:0];
        dvd_abs  = (bus.signed_i && bus.dividend_i[DATA_WIDTH-1]) ? -bus.dividend_i
                                                                   : bus.dividend_i;
        dsr_abs  = (bus.signed_i && bus.divisor_i[DATA_WIDTH-1]) ? -bus.divisor_i
                                                                  : bus.divisor_i;
        quo_fin  = q_neg ? -quo_next : quo_next;
        rem_fin  = r_neg ? -rem_next : rem_next;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i || bus.exception_i) begin
            state       <= IDLE;
            count       <= '0;
            rem         <= '0;
            quo         <= '0;
            dsr         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        if (bus.divisor_i == '0) begin
                            state       <= DONE;
                            quotient_r  <= '1;
                            remainder_r <= bus.dividend_i;
                            done_r      <= 1'b1;
                        end else begin
                            state  <= BUSY;
                            busy_r <= 1'b1;
                            count  <= '0;
                            rem    <= '0;
                            quo    <= dvd_abs;
                            dsr    <= dsr_abs;
                            q_neg  <= bus.signed_i &
                                      (bus.dividend_i[DATA_WIDTH-1] ^ bus.divisor_i[DATA_WIDTH-1]);
                            r_neg  <= bus.signed_i & bus.dividend_i[DATA_WIDTH-1];
                        end
                    end
                end
                BUSY: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state       <= DONE;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        quotient_r  <= quo_fin;
                        remainder_r <= rem_fin;
                    end
                end
                DONE: begin
                    if (bus.accept_i) begin
                        state       <= IDLE;
                        done_r      <= 1'b0;
                        quotient_r  <= '0;
                        remainder_r <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stall is combinational so EX holds in the very cycle a division is presented
    assign bus.stall_o     = ((state == IDLE) && bus.start_i) || (state == BUSY);
    assign bus.busy_o      = busy_r;
    assign bus.done_o      = done_r;
    assign bus.quotient_o  = quotient_r;
    assign bus.remainder_o = remainder_r;
endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Iterative 32-bit integer divider for the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes rs/rt operand data and the DIV/DIVU decode from the ID/EX register.
- Raises the EX stall (stall bit 2) while a division is in progress.
- Holds the quotient/remainder until the EX stage accepts them; they are then written to LO/HI.

Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count and latency derive from it.

Ports:
- clock_i  in  1  rising-edge clock
- reset_i  in  1  synchronous reset, active-high
- exception_i  in  1  pipeline flush; aborts any division in progress
- start_i  in  1  level; high while a DIV/DIVU occupies EX
- signed_i  in  1  1 = DIV (signed), 0 = DIVU; sampled with start_i
- dividend_i  in  DATA_WIDTH  rs data
- divisor_i  in  DATA_WIDTH  rt data
- accept_i  in  1  EX stage consumes result this cycle (EX not held by data stall)
- stall_o  out  1  EX stall request
- busy_o  out  1  state is BUSY
- done_o  out  1  result valid (state DONE)
- quotient_o  out  DATA_WIDTH  to LO
- remainder_o  out  DATA_WIDTH  to HI

Behaviour:
- Reset (reset_i=1 at a rising edge):
  - State goes to IDLE; counter, partial remainder, quotient register and latched operands go to 0.
  - Outputs: quotient_o=0, remainder_o=0, done_o=0, busy_o=0.
  - stall_o=0 in the following cycle unless start_i is high.
  - Reset overrides all other inputs.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If start_i=1 and divisor_i!=0: latch |dividend|, |divisor|, the quotient sign (signed_i & sign mismatch) and the remainder sign (signed_i & dividend MSB). Clear counter; go to BUSY.
  - If start_i=1 and divisor_i==0: go to DONE with quotient=all-ones, remainder=dividend_i (raw).
  - Otherwise stay in IDLE.
- BUSY:
  - One restoring step per cycle: shift {rem,quo} left by 1, trial-subtract the divisor, set the quotient LSB on no borrow.
  - Counter runs 0..DATA_WIDTH-1. At count DATA_WIDTH-1, apply sign correction (two's-complement negate of quotient/remainder per latched signs) and go to DONE.
- DONE:
  - done_o=1; quotient_o/remainder_o are stable and held indefinitely while accept_i=0.
  - accept_i=1: go to IDLE. The next division starts only from IDLE, so back-to-back divisions cost one IDLE cycle.
- Latency: start accepted in cycle 0, done_o=1 in cycle DATA_WIDTH+1 (33). Divide-by-zero: done_o=1 in cycle 1.
- stall_o = (IDLE & start_i) | BUSY. It is combinational, and 0 in DONE so EX can advance.
- quotient_o/remainder_o are only meaningful when done_o=1 and read 0 in IDLE/BUSY.
- Overflow case: 0x80000000 / -1 signed gives quotient 0x80000000, remainder 0. This falls out of the unsigned magnitude path; no special-casing.
- exception_i=1 at an edge, in any state: go to IDLE, clear registers as for reset, no done_o pulse. It takes priority over start_i and accept_i in the same cycle.
- Operands are sampled only on entering BUSY; input changes during BUSY/DONE are ignored.
- Reset or exception mid-BUSY discards the division; a subsequent start_i begins a fresh 33-cycle run.

Test Plan:
- Unsigned: start_i=1, signed_i=0, 100/7, accept_i=1.
  - stall_o=1 in cycles 0..32.
  - done_o=1 in cycle 33 with quotient=14, remainder=2.
  - IDLE in cycle 34.
- Signed:
  - -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - 7/-2 -> quotient 0xFFFFFFFD, remainder 1.
  - 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- Divide by zero: 0x12345678/0 -> done_o=1 in cycle 1, quotient 0xFFFFFFFF, remainder 0x12345678; no BUSY cycles.
- Hold: after done, accept_i=0 for 5 cycles.
  - done_o, quotient and remainder stay constant and stall_o=0.
  - accept_i=1 -> IDLE on the next edge.
- Flush: exception_i=1 in BUSY cycle 10.
  - IDLE next cycle, stall_o=0 with start_i=0, no done_o.
  - A new 0xFFFFFFFF/0x10 unsigned division gives quotient 0x0FFFFFFF, remainder 0xF at cycle 33.
- Priority:
  - reset_i=1 together with exception_i=1 and start_i=1 -> all outputs 0.
  - exception_i=1 with accept_i=1 in DONE -> IDLE, outputs 0.
